// File: rtl/spi_cfg_master.sv
// SPI master for the simpleFE configuration port.
// Sends 16-bit write / 24-bit read frames and returns the MISO bits.
module spi_cfg_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [23:0] rsp_data,
  output logic        busy,
  output logic        spi_ncs,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [15:0] SETUP_M1 = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_M1  = 16'(CS_HOLD - 1);
  localparam logic [15:0] IDLE_M1  = 16'(CS_IDLE - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [4:0]  bits;
  logic [23:0] tx;
  logic [23:0] rx;
  logic        cnt_zero;
  logic        gap_done;
  logic        accept;

  assign cnt_zero  = (cnt == 16'd0);
  // Ready on the last gap cycle so the ncs high gap is exactly CS_IDLE.
  assign gap_done  = (state == S_GAP) && cnt_zero;
  assign cmd_ready = (state == S_IDLE) || gap_done;
  assign busy      = !cmd_ready;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bits      <= '0;
      tx        <= '0;
      rx        <= '0;
      spi_ncs   <= 1'b1;
      spi_clk   <= 1'b1;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        state   <= S_SETUP;
        cnt     <= SETUP_M1;
        rx      <= '0;
        spi_ncs <= 1'b0;
        if (cmd_wr) begin
          bits <= 5'd16;
          tx   <= {1'b1, cmd_addr, 5'b0, cmd_data, 8'b0};
        end else begin
          bits <= 5'd24;
          tx   <= {1'b0, cmd_addr, 21'b0};
        end
      end else begin
        case (state)
          S_SETUP, S_HIGH: begin
            if (!cnt_zero) begin
              cnt <= cnt - 16'd1;
            end else if (state == S_SETUP || bits != 5'd0) begin
              spi_clk  <= 1'b0;
              spi_mosi <= tx[23];
              tx       <= {tx[22:0], 1'b0};
              rx       <= {rx[22:0], spi_miso};
              bits     <= bits - 5'd1;
              cnt      <= DIV_M1;
              state    <= S_LOW;
            end else begin
              cnt   <= HOLD_M1;
              state <= S_HOLD;
            end
          end
          S_LOW: begin
            if (!cnt_zero) begin
              cnt <= cnt - 16'd1;
            end else begin
              spi_clk <= 1'b1;
              cnt     <= DIV_M1;
              state   <= S_HIGH;
            end
          end
          S_HOLD: begin
            if (!cnt_zero) begin
              cnt <= cnt - 16'd1;
            end else begin
              spi_ncs   <= 1'b1;
              spi_mosi  <= 1'b0;
              rsp_data  <= rx;
              rsp_valid <= 1'b1;
              cnt       <= IDLE_M1;
              state     <= S_GAP;
            end
          end
          S_GAP: begin
            if (!cnt_zero) cnt <= cnt - 16'd1;
            else state <= S_IDLE;
          end
          S_IDLE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Bench for spi_cfg_master: default instance plus a fast
// (CLK_DIV=1, CS_*=1) instance sharing one bus monitor.
module tb_spi_cfg_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [1:0] cmd_addr = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       spi_miso = 1'b0;
  logic       sel = 1'b0;

  logic ncs0, sck0, mosi0, rdy0, busy0, rv0;
  logic ncs1, sck1, mosi1, rdy1, busy1, rv1;
  logic [23:0] rd0, rd1;
  logic v0, v1;
  assign v0 = cmd_valid & ~sel;
  assign v1 = cmd_valid & sel;

  spi_cfg_master u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rv0), .rsp_data(rd0), .busy(busy0),
    .spi_ncs(ncs0), .spi_clk(sck0), .spi_mosi(mosi0),
    .spi_miso(spi_miso)
  );

  spi_cfg_master #(
    .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)
  ) u_fast (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rv1), .rsp_data(rd1), .busy(busy1),
    .spi_ncs(ncs1), .spi_clk(sck1), .spi_mosi(mosi1),
    .spi_miso(spi_miso)
  );

  logic m_ncs, m_sck, m_mosi, m_rdy, m_busy, m_rv;
  logic [23:0] m_rd;
  assign m_ncs  = sel ? ncs1  : ncs0;
  assign m_sck  = sel ? sck1  : sck0;
  assign m_mosi = sel ? mosi1 : mosi0;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_rv   = sel ? rv1   : rv0;
  assign m_rd   = sel ? rd1   : rd0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    logic [23:0] mosi;
    logic [23:0] rsp;
    int          low;
  } exp_t;
  exp_t sb[$];

  logic [23:0] slave_pat = 24'h0;
  logic [23:0] slave_sh = 24'h0;

  logic p_ncs = 1'b1, p_sck = 1'b1, p_mosi = 1'b0;
  int fall_cyc = 0, rise_cyc = 0, gap_len = 0, low_len = 0;
  int nfalls = 0, nrises = 0, last_fall = 0, per = 0;
  int min_per = 0, max_per = 0;
  int rsp_cnt = 0, frames_started = 0, bad_edges = 0, bad_mosi = 0;
  logic [31:0] mosi_word = 32'h0;
  logic [23:0] f_mosi = 24'h0, f_rsp = 24'h0;
  int f_falls = 0, f_rises = 0, f_min = 0, f_max = 0;
  int f_lowlen = 0, f_rsp_at = 0, f_fall = 0;

  always @(negedge clk) begin
    if (p_ncs && !m_ncs) begin
      gap_len = cyc - rise_cyc;
      fall_cyc = cyc;
      nfalls = 0;
      nrises = 0;
      mosi_word = 32'h0;
      min_per = 1000000;
      max_per = 0;
      frames_started++;
      slave_sh = slave_pat;
      spi_miso = slave_sh[23];
    end
    if (!p_ncs && m_ncs) begin
      rise_cyc = cyc;
      low_len = cyc - fall_cyc;
    end
    if (p_sck != m_sck && p_ncs && m_ncs) bad_edges++;
    if (!m_ncs && p_sck && !m_sck) begin
      nfalls++;
      mosi_word = {mosi_word[30:0], m_mosi};
      if (nfalls > 1) begin
        per = cyc - last_fall;
        if (per < min_per) min_per = per;
        if (per > max_per) max_per = per;
      end
      last_fall = cyc;
    end
    if (!m_ncs && !p_sck && m_sck) begin
      nrises++;
      slave_sh = {slave_sh[22:0], 1'b0};
      spi_miso = slave_sh[23];
    end
    if (m_mosi != p_mosi && !(p_sck && !m_sck) && !(!p_ncs && m_ncs))
      bad_mosi++;
    if (m_rv) begin
      rsp_cnt++;
      f_rsp = m_rd;
      f_mosi = mosi_word[23:0];
      f_falls = nfalls;
      f_rises = nrises;
      f_min = min_per;
      f_max = max_per;
      f_lowlen = low_len;
      f_rsp_at = cyc - fall_cyc;
      f_fall = fall_cyc;
    end
    p_ncs = m_ncs;
    p_sck = m_sck;
    p_mosi = m_mosi;
  end

  task automatic issue(input logic wr, input logic [1:0] a,
                       input logic [7:0] d, input bit keep,
                       input bit push);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_wr = wr;
    cmd_addr = a;
    cmd_data = d;
    cmd_valid = 1'b1;
    n = 0;
    while (!m_rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (push) begin
      e.n = wr ? 16 : 24;
      e.mosi = wr ? {8'h00, 1'b1, a, 5'b0, d} : {1'b0, a, 21'b0};
      e.rsp = wr ? {8'h00, slave_pat[23:8]} : slave_pat;
      e.low = sel ? (2 + 2 * e.n) : (4 + 8 * e.n);
      sb.push_back(e);
    end
    @(negedge clk);
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_wr = ~wr;
      cmd_addr = ~a;
      cmd_data = ~d;
    end
  endtask

  task automatic wait_rsp(input int target, output bit ok);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    ok = (rsp_cnt >= target);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    @(negedge clk);
    vectors++;
    if ({ncs0, sck0, mosi0, rdy0, busy0, rv0} !== 6'b110100) begin
      miscompares++;
      $display("FAIL reset_ctl got %b need 110100",
               {ncs0, sck0, mosi0, rdy0, busy0, rv0});
    end
    vectors++;
    if (rd0 !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_rsp got %h need 000000", rd0);
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_write();
    exp_t e;
    bit ok;
    int base;
    sel = 1'b0;
    slave_pat = 24'h0;
    base = rsp_cnt;
    issue(1'b1, 2'd1, 8'h05, 1'b0, 1'b1);
    wait_rsp(base + 1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wr_timeout rsp_cnt=%0d need %0d", rsp_cnt, base + 1);
    end
    e = sb.pop_front();
    vectors++;
    if (f_mosi !== e.mosi || e.mosi !== 24'h00A005) begin
      miscompares++;
      $display("FAIL wr_mosi got %h need %h", f_mosi, e.mosi);
    end
    vectors++;
    if (f_falls != e.n || f_rises != e.n) begin
      miscompares++;
      $display("FAIL wr_edges got %0d/%0d need %0d", f_falls, f_rises, e.n);
    end
    vectors++;
    if (f_lowlen != e.low || f_lowlen != 132) begin
      miscompares++;
      $display("FAIL wr_ncs_low got %0d need 132", f_lowlen);
    end
    vectors++;
    if (f_min != 8 || f_max != 8) begin
      miscompares++;
      $display("FAIL wr_period got %0d..%0d need 8", f_min, f_max);
    end
    vectors++;
    if (f_rsp_at != 132) begin
      miscompares++;
      $display("FAIL wr_rsp_time got %0d need 132", f_rsp_at);
    end
    vectors++;
    if (f_rsp !== e.rsp) begin
      miscompares++;
      $display("FAIL wr_rsp got %h need %h", f_rsp, e.rsp);
    end
    idle(10);
    vectors++;
    if (rsp_cnt != base + 1) begin
      miscompares++;
      $display("FAIL wr_pulses got %0d need 1", rsp_cnt - base);
    end
  endtask

  task automatic test_read();
    exp_t e;
    bit ok;
    int base;
    sel = 1'b0;
    slave_pat = 24'hC3A55A;
    base = rsp_cnt;
    issue(1'b0, 2'd0, 8'hFF, 1'b0, 1'b1);
    wait_rsp(base + 1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rd_timeout rsp_cnt=%0d need %0d", rsp_cnt, base + 1);
    end
    e = sb.pop_front();
    vectors++;
    if (f_mosi !== e.mosi || f_falls != 24 || f_rises != 24) begin
      miscompares++;
      $display("FAIL rd_frame mosi %h falls %0d rises %0d need %h/24/24",
               f_mosi, f_falls, f_rises, e.mosi);
    end
    vectors++;
    if (f_rsp !== e.rsp) begin
      miscompares++;
      $display("FAIL rd_rsp got %h need %h", f_rsp, e.rsp);
    end
    vectors++;
    if (f_lowlen != e.low || f_lowlen != 196) begin
      miscompares++;
      $display("FAIL rd_ncs_low got %0d need 196", f_lowlen);
    end
    idle(5);
    slave_pat = 24'h0;
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit ok;
    int n;
    int base;
    sel = 1'b0;
    base = rsp_cnt;
    issue(1'b1, 2'd3, 8'h3C, 1'b0, 1'b0);
    n = 0;
    while (nfalls < 7 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ncs0, sck0, mosi0, busy0, rdy0} !== 5'b11001) begin
      miscompares++;
      $display("FAIL rst_now got %b need 11001",
               {ncs0, sck0, mosi0, busy0, rdy0});
    end
    vectors++;
    if (rd0 !== 24'h0) begin
      miscompares++;
      $display("FAIL rst_rsp got %h need 000000", rd0);
    end
    idle(4);
    @(negedge clk);
    rst_n = 1'b1;
    idle(200);
    vectors++;
    if (rsp_cnt != base) begin
      miscompares++;
      $display("FAIL rst_no_rsp got %0d need 0", rsp_cnt - base);
    end
    issue(1'b1, 2'd2, 8'h96, 1'b0, 1'b1);
    wait_rsp(base + 1, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || f_mosi !== e.mosi || f_falls != 16) begin
      miscompares++;
      $display("FAIL rst_next mosi %h falls %0d need %h/16",
               f_mosi, f_falls, e.mosi);
    end
    idle(5);
  endtask

  task automatic test_fast();
    exp_t e;
    bit ok;
    int base;
    sel = 1'b1;
    slave_pat = 24'h5A0F3C;
    base = rsp_cnt;
    issue(1'b1, 2'd0, 8'h1F, 1'b1, 1'b1);
    issue(1'b0, 2'd2, 8'h00, 1'b0, 1'b1);
    wait_rsp(base + 1, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || f_mosi !== e.mosi || e.mosi !== 24'h00801F) begin
      miscompares++;
      $display("FAIL fast_mosi got %h need %h", f_mosi, e.mosi);
    end
    vectors++;
    if (f_min != 2 || f_max != 2) begin
      miscompares++;
      $display("FAIL fast_period got %0d..%0d need 2", f_min, f_max);
    end
    vectors++;
    if (f_lowlen != e.low || f_lowlen != 34) begin
      miscompares++;
      $display("FAIL fast_ncs_low got %0d need 34", f_lowlen);
    end
    vectors++;
    if (f_rsp !== e.rsp) begin
      miscompares++;
      $display("FAIL fast_wr_rsp got %h need %h", f_rsp, e.rsp);
    end
    wait_rsp(base + 2, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || gap_len != 1) begin
      miscompares++;
      $display("FAIL fast_gap got %0d need 1", gap_len);
    end
    vectors++;
    if (f_mosi !== e.mosi || f_rsp !== e.rsp || f_lowlen != e.low) begin
      miscompares++;
      $display("FAIL fast_rd mosi %h rsp %h low %0d need %h/%h/%0d",
               f_mosi, f_rsp, f_lowlen, e.mosi, e.rsp, e.low);
    end
    idle(5);
    @(negedge clk);
    sel = 1'b0;
    slave_pat = 24'h0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    int base;
    int first_fall;
    sel = 1'b0;
    base = rsp_cnt;
    issue(1'b1, 2'd2, 8'hA0, 1'b1, 1'b1);
    issue(1'b0, 2'd3, 8'h00, 1'b0, 1'b1);
    wait_rsp(base + 1, ok);
    e = sb.pop_front();
    first_fall = f_fall;
    vectors++;
    if (!ok || f_mosi !== e.mosi) begin
      miscompares++;
      $display("FAIL b2b_first got %h need %h", f_mosi, e.mosi);
    end
    wait_rsp(base + 2, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || gap_len != 2) begin
      miscompares++;
      $display("FAIL b2b_gap got %0d need 2", gap_len);
    end
    vectors++;
    if (f_fall - first_fall != 134) begin
      miscompares++;
      $display("FAIL b2b_accept got %0d need 134", f_fall - first_fall);
    end
    vectors++;
    if (f_mosi !== e.mosi || e.mosi !== 24'h600000) begin
      miscompares++;
      $display("FAIL b2b_second got %h need %h", f_mosi, e.mosi);
    end
    idle(5);
  endtask

  task automatic test_busy_pulse();
    exp_t e;
    bit ok;
    int base;
    int fs;
    sel = 1'b0;
    base = rsp_cnt;
    fs = frames_started;
    issue(1'b1, 2'd1, 8'h5A, 1'b0, 1'b1);
    idle(20);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr = 1'b0;
    cmd_addr = 2'd3;
    vectors++;
    if (m_busy !== 1'b1 || m_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_flag got %b%b need 10", m_busy, m_rdy);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(base + 1, ok);
    e = sb.pop_front();
    idle(300);
    vectors++;
    if (!ok || f_mosi !== e.mosi) begin
      miscompares++;
      $display("FAIL busy_mosi got %h need %h", f_mosi, e.mosi);
    end
    vectors++;
    if (rsp_cnt - base != 1 || frames_started - fs != 1) begin
      miscompares++;
      $display("FAIL busy_ignore rsp %0d frames %0d need 1/1",
               rsp_cnt - base, frames_started - fs);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mid_reset();
    test_fast();
    test_back_to_back();
    test_busy_pulse();
    vectors++;
    if (bad_edges != 0 || bad_mosi != 0) begin
      miscompares++;
      $display("FAIL bus_rules sclk_idle %0d mosi_glitch %0d need 0/0",
               bad_edges, bad_mosi);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_left got %0d need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_cfg_master.md
Name: spi_cfg_master

Overview:
- SPI master that drives the configuration port of the simpleFE core (spi_ncs_i / spi_clk_i / spi_mosi / spi_miso).
- Used on the companion controller board and in system-level benches in place of hand-written SPI tasks.
- Accepts one register command at a time and serialises it as a 16-bit write frame or a 24-bit read frame.
- Returns the bits captured from MISO.

Parameters:
CLK_DIV, 4, sys clocks per SCLK half-period (>=1)
CS_SETUP, 2, clocks from ncs fall to first SCLK fall (>=1)
CS_HOLD, 2, clocks from end of last SCLK high half to ncs rise (>=1)
CS_IDLE, 2, clocks ncs held high before next command is accepted (>=1)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when idle; command accepted on cmd_valid & cmd_ready
cmd_wr  in  1  1 = 16-bit write frame, 0 = 24-bit read frame
cmd_addr  in  2  register address
cmd_data  in  8  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse at end of every frame
rsp_data  out  24  MISO bits of last frame, MSB first; writes fill [15:0], [23:16]=0
busy  out  1  high from accept until cmd_ready returns
spi_ncs  out  1  chip select, active low
spi_clk  out  1  SCLK, idles high
spi_mosi  out  1  serial data to slave
spi_miso  in  1  serial data from slave

Behaviour:
- Reset (async, immediate, also mid-frame): spi_ncs=1, spi_clk=1, spi_mosi=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0; counters and state cleared. A partial frame is abandoned with no rsp_valid.
- Frame formats, MSB first:
  - write: {1, addr[1:0], 5'b0, data[7:0]}, N=16
  - read: {0, addr[1:0], 21'b0}, N=24
- FSM states: IDLE, SETUP, LOW, HIGH, HOLD, GAP.
- IDLE:
  - cmd_ready=1.
  - On accept at edge E0: load shift register and bit counter, spi_ncs<=0, busy<=1, cmd_ready<=0, go to SETUP.
- SETUP: hold CS_SETUP clocks. Then, at edge E0+CS_SETUP:
  - spi_clk<=0
  - spi_mosi<=frame MSB
  - sample spi_miso into rx shift LSB
  - go to LOW
- LOW: after CLK_DIV clocks, spi_clk<=1, go to HIGH.
- HIGH, after CLK_DIV clocks:
  - bits remain: spi_clk<=0, drive next MOSI bit, sample spi_miso, go to LOW.
  - else: go to HOLD; spi_clk stays 1.
- MISO sampling: the value of spi_miso present at the clk edge that drives SCLK low. Exactly N samples per frame, first sample = rsp_data MSB of the frame.
- HOLD: after CS_HOLD clocks:
  - spi_ncs<=1, spi_mosi<=0
  - rsp_data<=captured bits, rsp_valid<=1 for one cycle
  - go to GAP
- GAP: after CS_IDLE clocks, cmd_ready<=1, busy<=0, go to IDLE.
- Exact timing from E0:
  - k-th SCLK fall (k=1..N) at E0+CS_SETUP+(2k-2)*CLK_DIV
  - k-th rise at E0+CS_SETUP+(2k-1)*CLK_DIV
  - ncs rise / rsp_valid at E0+CS_SETUP+2N*CLK_DIV+CS_HOLD
  - cmd_ready at that edge + CS_IDLE
- Defaults:
  - write: ncs low 132 clocks, next accept 134 clocks after E0
  - read: ncs low 196 clocks
- Exactly N falling and N rising SCLK edges per frame; no SCLK edge while ncs high. MOSI changes only on SCLK-fall edges or at ncs rise.
- cmd_valid while not ready is ignored (not queued). Command fields are latched at accept; later changes have no effect.
- Back-to-back: cmd_valid held high yields a new accept on the first cycle cmd_ready=1. The ncs high gap is exactly CS_IDLE clocks.
- Counters are 16 bits; CLK_DIV/CS_* > 65535 is unsupported.

Test Plan:
- Write addr=1 data=0x05, defaults:
  - MOSI on 16 falls = 0xA005
  - ncs low 132 clocks
  - SCLK fall-to-fall period 8 clocks
  - rsp_valid one pulse at E0+132
  - rsp_data=0x000000 (MISO tied 0)
- Read addr=0 against bench slave returning 0xC3A55A on MISO (changes after each SCLK rise):
  - MOSI all 0
  - 24 SCLK cycles
  - rsp_data=0xC3A55A
  - ncs low 196 clocks
- CLK_DIV=1, CS_SETUP=CS_HOLD=CS_IDLE=1, write 0x1F to addr 0:
  - MOSI 0x801F
  - SCLK period 2 clocks
  - ncs low 34 clocks
  - next cmd_ready 1 clock after ncs rise
- Back-to-back: cmd_valid held for write 0xA0 addr 2 then read addr 3:
  - ncs high exactly CS_IDLE=2 clocks between frames
  - second frame MOSI = 0x600000
- rst_n low after 7 SCLK falls of a write:
  - same instant: ncs=1, spi_clk=1, mosi=0, busy=0
  - no rsp_valid
  - next write after release transmits full correct 16 bits
- cmd_valid pulsed while busy: ignored; exactly one frame and one rsp_valid observed.
